// File: rtl/pmod_jstk_responder.sv
// PmodJSTK emulator: SPI mode-0 responder that returns X/Y/buttons in a 5-byte frame
// and latches the LED bits from a valid command byte. SPI pins are oversampled on Clk.
module pmod_jstk_responder (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       SS,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [9:0] X_Pos,
    input  logic [9:0] Y_Pos,
    input  logic [2:0] Buttons,
    output logic [1:0] Led,
    output logic       Frame_Done,
    output logic       Frame_Error
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned POS_W   = 10;
    localparam int unsigned BTN_W   = 3;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned TOT_W   = 6;
    localparam int unsigned SETTLE_W = 2;

    localparam logic [TOT_W-1:0]    FRAME_BITS = TOT_W'(40);
    localparam logic [TOT_W-1:0]    TOT_MAX    = TOT_W'(63);
    localparam logic [CNT_W-1:0]    IDX_MAX    = CNT_W'(5);
    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(3);
    localparam logic [5:0]          LED_CMD    = 6'b100000;

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    state_t state, state_next;

    logic ss_s1, ss_s2, ss_d;
    logic sclk_s1, sclk_s2, sclk_d;
    logic mosi_s1, mosi_s2, mosi_d;
    logic ss_rise, ss_fall, sclk_rise, sclk_fall;

    logic [SETTLE_W-1:0] settle;
    logic [POS_W-1:0]    snap_x, snap_y;
    logic [BTN_W-1:0]    snap_btn;
    logic [BYTE_W-1:0]   tx;
    logic [BYTE_W-2:0]   rx;
    logic [BYTE_W-1:0]   cmd;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    byte_idx;
    logic [TOT_W-1:0]    total_bits;

    logic              start_c, end_c, rise_c, fall_c;
    logic [BYTE_W-1:0] tx_byte_c, tx_next_c;

    // 2-FF synchronisers, delayed copy, and registered edge strobes
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            {ss_s1, ss_s2, ss_d}       <= 3'b111;
            {sclk_s1, sclk_s2, sclk_d} <= 3'b000;
            {mosi_s1, mosi_s2, mosi_d} <= 3'b000;
            ss_rise   <= 1'b0;
            ss_fall   <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
        end else begin
            {ss_s1, ss_s2, ss_d}       <= {SS, ss_s1, ss_s2};
            {sclk_s1, sclk_s2, sclk_d} <= {SCLK, sclk_s1, sclk_s2};
            {mosi_s1, mosi_s2, mosi_d} <= {MOSI, mosi_s1, mosi_s2};
            ss_rise   <= ss_s2 & ~ss_d;
            ss_fall   <= ~ss_s2 & ss_d;
            sclk_rise <= sclk_s2 & ~sclk_d;
            sclk_fall <= ~sclk_s2 & sclk_d;
        end
    end

    // Settle counter lets the synchroniser flush its reset value of SS before trusting it
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            settle <= '0;
        end else if (state == WAIT_HIGH && settle != SETTLE_MAX) begin
            settle <= settle + SETTLE_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= WAIT_HIGH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_HIGH: if (settle == SETTLE_MAX && ss_s2 && ss_d) state_next = IDLE;
            IDLE:      if (ss_fall) state_next = ACTIVE;
            ACTIVE:    if (ss_rise) state_next = IDLE;
            default:   state_next = WAIT_HIGH;
        endcase
    end

    // SS rise takes priority over a coincident SCLK strobe
    always_comb begin
        start_c = (state == IDLE) && ss_fall;
        end_c   = (state == ACTIVE) && ss_rise;
        rise_c  = (state == ACTIVE) && !ss_rise && sclk_rise;
        fall_c  = (state == ACTIVE) && !ss_rise && sclk_fall;

        case (byte_idx)
            3'd0:    tx_byte_c = snap_x[7:0];
            3'd1:    tx_byte_c = {6'b0, snap_x[9:8]};
            3'd2:    tx_byte_c = snap_y[7:0];
            3'd3:    tx_byte_c = {6'b0, snap_y[9:8]};
            3'd4:    tx_byte_c = {5'b0, snap_btn};
            default: tx_byte_c = '0;
        endcase

        tx_next_c = tx;
        if (start_c) begin
            tx_next_c = X_Pos[7:0];
        end else if (fall_c) begin
            tx_next_c = (bit_cnt == '0) ? tx_byte_c : {tx[6:0], 1'b0};
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            tx          <= '0;
            MISO        <= 1'b0;
            rx          <= '0;
            cmd         <= '0;
            bit_cnt     <= '0;
            byte_idx    <= '0;
            total_bits  <= '0;
            snap_x      <= '0;
            snap_y      <= '0;
            snap_btn    <= '0;
            Led         <= 2'b00;
            Frame_Done  <= 1'b0;
            Frame_Error <= 1'b0;
        end else begin
            tx          <= tx_next_c;
            MISO        <= (state_next == ACTIVE) ? tx_next_c[7] : 1'b0;
            Frame_Done  <= 1'b0;
            Frame_Error <= 1'b0;

            if (start_c) begin
                snap_x     <= X_Pos;
                snap_y     <= Y_Pos;
                snap_btn   <= Buttons;
                bit_cnt    <= '0;
                byte_idx   <= '0;
                total_bits <= '0;
            end

            if (rise_c) begin
                rx      <= {rx[5:0], mosi_d};
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (total_bits != TOT_MAX) begin
                    total_bits <= total_bits + TOT_W'(1);
                end
                if (bit_cnt == CNT_W'(7)) begin
                    if (byte_idx != IDX_MAX) begin
                        byte_idx <= byte_idx + CNT_W'(1);
                    end
                    if (byte_idx == '0) begin
                        cmd <= {rx, mosi_d};
                    end
                end
            end

            if (end_c) begin
                if (total_bits == FRAME_BITS) begin
                    Frame_Done <= 1'b1;
                    if (cmd[7:2] == LED_CMD) begin
                        Led <= cmd[1:0];
                    end
                end else begin
                    Frame_Error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/pmod_jstk_responder.md
# pmod_jstk_responder

SPI responder (slave) that emulates a PmodJSTK on the joystick port, for loopback and self-test of the game's existing SPI joystick master. The master already drives SS, SCLK and MOSI and samples MISO. This block answers each 5-byte transaction with the joystick X, Y and button values presented on its inputs, and latches the two LED-command bits the master sends. It sits on the board_clk domain and oversamples the SPI pins.

## Interface
- No parameters.
- Clk: input, 1 bit. System clock (board_clk, 100 MHz); all logic is on its rising edge.
- Reset: input, 1 bit. Synchronous, active-low reset.
- SS: input, 1 bit. Slave select from the master, active low; asynchronous to Clk.
- SCLK: input, 1 bit. SPI clock from the master, mode 0 (CPOL=0, CPHA=0); asynchronous to Clk.
- MOSI: input, 1 bit. Data from the master, MSB first.
- MISO: output, 1 bit. Data to the master, MSB first.
- X_Pos: input, 10 bits. Emulated X position, 0–1023.
- Y_Pos: input, 10 bits. Emulated Y position, 0–1023.
- Buttons: input, 3 bits. Emulated button state {btn2, btn1, trigger}.
- Led: output, 2 bits. LED bits from the last valid command byte.
- Frame_Done: output, 1 bit. One-Clk pulse when a complete 40-bit frame ends.
- Frame_Error: output, 1 bit. One-Clk pulse when a frame ends with a bit count other than 40.

## Operation
- **Input synchronisers.** SS, SCLK and MOSI each pass through a 2-FF synchroniser, followed by a registered copy used for edge detection.
- **Synchroniser reset values.** SS = 1, SCLK = 0, MOSI = 0.
- **States.**
  - WAIT_HIGH: the reset state. Go to IDLE once the synchronised SS is 1.
  - IDLE: on an SS falling edge, go to ACTIVE.
  - ACTIVE: on an SS rising edge, go to IDLE.
- **Frame start (entering ACTIVE).**
  - Snapshot X_Pos, Y_Pos and Buttons into a 40-bit TX image.
  - Byte 0 = X[7:0]; byte 1 = {6'b0, X[9:8]}; byte 2 = Y[7:0]; byte 3 = {6'b0, Y[9:8]}; byte 4 = {5'b0, Buttons}.
  - Load byte 0 into the TX shift register and clear bit_cnt[2:0], byte_idx[2:0] and total_bits[5:0].
- **SCLK rising edge in ACTIVE.**
  - Shift MOSI into the RX shift register.
  - bit_cnt increments and wraps 7→0.
  - total_bits increments and saturates at 63.
  - When bit_cnt wraps: byte_idx increments (saturating at 5), and if byte_idx was 0 the completed RX byte is stored as cmd.
- **SCLK falling edge in ACTIVE.**
  - If bit_cnt == 0 (a byte has just completed), load TX byte[byte_idx]; for byte_idx ≥ 5 load 0x00.
  - Otherwise shift the TX register left, filling with 0.
- **MISO.** MISO = TX[7] while ACTIVE, and 0 otherwise.
- **Frame end (SS rising edge in ACTIVE).**
  - If total_bits == 40: pulse Frame_Done. If cmd[7:2] == 6'b100000, set Led ← cmd[1:0]; otherwise Led is held.
  - Else: pulse Frame_Error and hold Led.
- **SCLK edges outside ACTIVE** are ignored.
- **Input changes.** X_Pos, Y_Pos and Buttons changing mid-frame does not affect the frame in progress.

## Timing
- **Reset values.** MISO = 0, Led = 2'b00, Frame_Done = 0, Frame_Error = 0, state = WAIT_HIGH, and all counters 0.
- **Pin-to-edge latency.** 3 Clk from a pin transition to its internal edge strobe. MISO updates 4 Clk after a pin edge (SS fall or SCLK fall).
- **Master requirements:**
  - SCLK high and low phases ≥ 8 Clk each.
  - SS fall to first SCLK rise ≥ 8 Clk.
  - Last SCLK fall to SS rise ≥ 8 Clk.
  - The standard 66.7 kHz master meets these with wide margin.
- **Result latency.** Frame_Done / Frame_Error assert 4 Clk after the SS pin rises. Led updates in the same cycle Frame_Done asserts.
- **Reset mid-frame.** The frame is abandoned and MISO is 0 on the next cycle. The block returns to WAIT_HIGH, so an SS that is still low is not treated as a new frame; a fresh SS high→low is required.
- **Simultaneous SS rise and SCLK edge strobe.** The SS rise wins and the SCLK edge is discarded.

## Test plan
- **Basic frame.** X_Pos=0x2A5, Y_Pos=0x13C, Buttons=3'b101; master sends 0x83,0,0,0,0 → MISO bytes 0xA5, 0x02, 0x3C, 0x01, 0x05; Frame_Done pulses once; Led = 2'b11.
- **Invalid command.** First byte 0x42 with a 40-bit frame → Frame_Done pulses; Led stays at its previous value (2'b11).
- **Short and long frames.** SS rises after 20 bits → Frame_Error pulses and Led is unchanged. A 48-bit frame → byte 5 on MISO is 0x00 and Frame_Error pulses.
- **Mid-frame input change.** Change X_Pos from 0x000 to 0x3FF during byte 2 → the frame still returns X bytes 0x00 and 0x00; the next frame returns 0xFF and 0x03.
- **Reset mid-frame.** Assert Reset after 13 bits while SS is held low, release it, then continue clocking SCLK → MISO = 0, no Frame_Done or Frame_Error; the next full frame responds correctly.
- **Minimum timing.** Run a frame at the minimum 8-Clk SCLK phase with random X/Y/Buttons over 1000 frames → every MISO byte matches the snapshot.
